// File: rtl/spi_cfg_master.sv
// SPI configuration write master (mode 0, MSB first).
// One request sends a 16-bit frame {addr, data}. After the frame a flush
// pulse is issued with SSEL released so the slave can clear its counters.
// ack reports whether MISO was high at every SCLK high-half sample.
//
// Request handshake: a request is taken on a rising clk edge where
// req_valid && req_ready; req_ready is high only in IDLE.
// req_addr/req_data are copied into the shift register at that edge and
// are never read again during the frame.
module spi_cfg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       SCLK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO,
  output logic       done,
  output logic       ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        sclk_q;
  logic        ssel_q;
  logic        miss;
  logic        miso_meta;
  logic        miso_sync;

  // MOSI is the top bit of the shift register, so it comes straight from a flop.
  assign MOSI      = shreg[15];
  assign SCLK      = sclk_q;
  assign SSEL      = ssel_q;
  assign req_ready = (state == ST_IDLE);

  // Two-flop synchronizer for the asynchronous MISO line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_sync <= miso_meta;
    end
  end

  // Frame sequencer: phase timing, bit shifting, MISO accumulation and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      bit_cnt <= 4'd0;
      shreg   <= 16'd0;
      sclk_q  <= 1'b0;
      ssel_q  <= 1'b1;
      miss    <= 1'b0;
      done    <= 1'b0;
      ack     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state   <= ST_SETUP;
            shreg   <= {req_addr, req_data};
            cnt     <= RELOAD;
            bit_cnt <= 4'd0;
            miss    <= 1'b0;
            ack     <= 1'b0;
            ssel_q  <= 1'b0;
            sclk_q  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state  <= ST_SHIFT;
            sclk_q <= 1'b1;
            cnt    <= RELOAD;
          end
        end
        ST_SHIFT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            cnt <= RELOAD;
            if (sclk_q) begin
              // End of high half: sample MISO, fall, advance MOSI except in slot 16.
              sclk_q <= 1'b0;
              miss   <= miss | ~miso_sync;
              if (bit_cnt != 4'd15) begin
                shreg <= {shreg[14:0], 1'b0};
              end
            end else begin
              // End of low half: next slot, or the frame ends on wrap from 15.
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                state  <= ST_GAP;
                ssel_q <= 1'b1;
                shreg  <= 16'd0;
              end else begin
                sclk_q <= 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (!sclk_q) begin
            // Flush pulse with SSEL high.
            sclk_q <= 1'b1;
            cnt    <= RELOAD;
          end else begin
            state  <= ST_IDLE;
            sclk_q <= 1'b0;
            cnt    <= 8'd0;
            done   <= 1'b1;
            ack    <= ~miss;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: two instances (CLK_DIV 4 and 3) share stimulus;
// one is selected for observation. A negedge monitor reconstructs frames and
// compares them against an expected queue filled when requests are accepted.
module tb_spi_cfg_master;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       miso;

  logic ready4, sclk4, ssel4, mosi4, done4, ack4;
  logic ready3, sclk3, ssel3, mosi3, done3, ack3;
  logic o_ready, o_sclk, o_ssel, o_mosi, o_done, o_ack;
  logic sel3;

  int n_checks;
  int n_fail;

  spi_cfg_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(ready4), .SCLK(sclk4), .SSEL(ssel4),
    .MOSI(mosi4), .MISO(miso), .done(done4), .ack(ack4)
  );

  spi_cfg_master #(.CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(ready3), .SCLK(sclk3), .SSEL(ssel3),
    .MOSI(mosi3), .MISO(miso), .done(done3), .ack(ack3)
  );

  assign o_ready = sel3 ? ready3 : ready4;
  assign o_sclk  = sel3 ? sclk3  : sclk4;
  assign o_ssel  = sel3 ? ssel3  : ssel4;
  assign o_mosi  = sel3 ? mosi3  : mosi4;
  assign o_done  = sel3 ? done3  : done4;
  assign o_ack   = sel3 ? ack3   : ack4;

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // MISO modes: 0 tied 1, 1 tied 0, 2 low in slot 9 high half, 3 low in slot 9 low half.
  int   cur_mode;
  logic cur_exp_ack;

  // Scoreboard: {ack, addr, data} pushed on accept.
  logic [16:0] exp_q[$];

  bit          active;
  int          lat, ssel_low, gap_rise, mon_rise, mosi_err, ready_err;
  logic [15:0] word;
  logic        prev_sclk, prev_mosi, prev_ssel;

  // Frame monitor and MISO stimulus, sampled on the falling clock edge.
  always @(negedge clk) begin
    int d;
    logic [16:0] e;
    d = sel3 ? 3 : 4;
    if (!rst_n) begin
      active = 0;
      exp_q.delete();
    end else begin
      if (active) begin
        lat++;
        if (!o_ssel) ssel_low++;
        if (o_sclk && !prev_sclk) begin
          if (!o_ssel) begin
            mon_rise++;
            word = {word[14:0], o_mosi};
            if (cur_mode == 2 && mon_rise == 9) miso = 1'b0;
            if (cur_mode == 3 && mon_rise == 10) miso = 1'b1;
          end else begin
            gap_rise++;
          end
        end
        if (prev_sclk && !o_sclk && !o_ssel) begin
          if (cur_mode == 2 && mon_rise == 9) miso = 1'b1;
          if (cur_mode == 3 && mon_rise == 9) miso = 1'b0;
        end
        if (!o_ssel && !prev_ssel && (o_mosi != prev_mosi) && !(prev_sclk && !o_sclk)) mosi_err++;
        if (o_ssel && o_mosi) mosi_err++;
        if (o_ready != o_done) ready_err++;
        if (o_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("mosi_word", int'(word), int'(e[15:0]));
            chk("ack", int'(o_ack), int'(e[16]));
            chk("latency", lat, 1 + 35 * d);
            chk("ssel_low_cycles", ssel_low, 33 * d);
            chk("sclk_rises", mon_rise, 16);
            chk("flush_pulses", gap_rise, 1);
            chk("mosi_changes_bad", mosi_err, 0);
            chk("ready_while_busy", ready_err, 0);
          end
          active = 0;
        end
      end
      if (req_valid && o_ready) begin
        exp_q.push_back({cur_exp_ack, req_addr, req_data});
        active    = 1;
        lat       = 0;
        ssel_low  = 0;
        gap_rise  = 0;
        mon_rise  = 0;
        mosi_err  = 0;
        ready_err = 0;
        word      = 16'd0;
      end
    end
    prev_sclk = o_sclk;
    prev_mosi = o_mosi;
    prev_ssel = o_ssel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready && n < 400) begin
      tick();
      n++;
    end
    if (!o_ready) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    int lim;
    n = 0;
    lim = 40 * (sel3 ? 3 : 4) + 60;
    while (!o_done && n < lim) begin
      tick();
      n++;
    end
    if (!o_done) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic start_req(input logic [7:0] a, input logic [7:0] dt, input int mode, input logic ea);
    cur_mode    = mode;
    cur_exp_ack = ea;
    miso        = (mode == 1) ? 1'b0 : 1'b1;
    wait_ready();
    req_addr  = a;
    req_data  = dt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] dt, input int mode, input logic ea);
    start_req(a, dt, mode, ea);
    wait_done();
    repeat (3) tick();
    chk("ack_held", int'(o_ack), int'(ea));
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         mode;
    logic       exp_ack;
    logic       div3;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cnt;
    n_checks  = 0;
    n_fail    = 0;
    sel3      = 1'b0;
    req_valid = 1'b0;
    req_addr  = 8'h00;
    req_data  = 8'h00;
    miso      = 1'b1;
    cur_mode  = 0;
    cur_exp_ack = 1'b1;
    rst_n     = 1'b1;

    vecs[0] = '{8'h01, 8'h2A, 0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 8'h2A, 1, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 8'h2A, 2, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 8'h3C, 3, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 0, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 0, 1'b1, 1'b0};
    vecs[6] = '{8'h01, 8'h2A, 0, 1'b1, 1'b1};
    vecs[7] = '{8'h5A, 8'hC3, 1, 1'b0, 1'b1};
    vecs[8] = '{8'h01, 8'h2A, 2, 1'b0, 1'b1};

    // Reset and reset-state checks.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ssel", int'(o_ssel), 1);
    chk("rst_sclk", int'(o_sclk), 0);
    chk("rst_mosi", int'(o_mosi), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_ack", int'(o_ack), 0);
    chk("rst_ready", int'(o_ready), 1);
    repeat (4) tick();
    rst_n = 1'b1;
    tick();

    // Table-driven frames.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].div3 != sel3) begin
        repeat (400) tick();
        sel3 = vecs[i].div3;
      end
      run_frame(vecs[i].addr, vecs[i].data, vecs[i].mode, vecs[i].exp_ack);
    end
    repeat (400) tick();
    sel3 = 1'b0;

    // Back-to-back frames with req_valid held high.
    cur_mode = 0; cur_exp_ack = 1'b1; miso = 1'b1;
    wait_ready();
    req_addr = 8'h11; req_data = 8'h22; req_valid = 1'b1;
    tick();
    req_addr = 8'h33; req_data = 8'h44;
    wait_done();
    tick();
    req_addr = 8'h55; req_data = 8'h66;
    wait_done();
    tick();
    req_valid = 1'b0;
    wait_done();
    tick();
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Inputs changed and a stray request during the frame.
    start_req(8'h3C, 8'h96, 0, 1'b1);
    repeat (40) tick();
    req_addr = 8'hFF; req_data = 8'h00; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_done();
    cnt = 0;
    repeat (60) begin
      tick();
      if (!o_ssel) cnt++;
    end
    chk("no_second_frame", cnt, 0);

    // Reset during slot 7, then a normal frame right after release.
    start_req(8'h5A, 8'hC3, 0, 1'b1);
    cnt = 0;
    while (mon_rise < 7 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("reached_slot7", mon_rise, 7);
    #13 rst_n = 1'b0;
    #1;
    chk("abort_ssel", int'(o_ssel), 1);
    chk("abort_sclk", int'(o_sclk), 0);
    chk("abort_mosi", int'(o_mosi), 0);
    cnt = 0;
    repeat (5) begin
      tick();
      if (o_done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    cur_mode = 0; cur_exp_ack = 1'b1; miso = 1'b1;
    rst_n = 1'b1;
    req_addr = 8'hC0; req_data = 8'hDE; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_done();
    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
